// File: rtl/spi_cfg_arbiter_if.sv
// Requester handshake and SPI pin bundle for the shared converter config bus.
interface spi_cfg_arbiter_if #(
    parameter int unsigned FRAME_W = 16
);
    // DAC config engine (requester 0)
    logic               req0;
    logic [FRAME_W-1:0] word0;
    logic               last0;
    logic               ack0;
    logic               done0;
    // ADC config engine (requester 1)
    logic               req1;
    logic [FRAME_W-1:0] word1;
    logic               last1;
    logic               ack1;
    logic               done1;
    // SPI pins and status
    logic               sclk;
    logic               sdio;
    logic               csb;
    logic               busy;
    logic               owner;

    // Requester side: drives requests, observes acks and the bus
    modport master (
        output req0, word0, last0, req1, word1, last1,
        input  ack0, done0, ack1, done1, sclk, sdio, csb, busy, owner
    );

    // Arbiter side
    modport slave (
        input  req0, word0, last0, req1, word1, last1,
        output ack0, done0, ack1, done1, sclk, sdio, csb, busy, owner
    );
endinterface

// File: rtl/spi_cfg_arbiter.sv
// Shared 3-wire SPI master with DAC-before-ADC arbitration and burst locking.
module spi_cfg_arbiter #(
    parameter int unsigned FRAME_W = 16,
    parameter int unsigned DIV     = 512,
    parameter int unsigned GAP     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    spi_cfg_arbiter_if.slave bus_if
);

    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
    // The csb-rise/ack cycle always lives in GAP so a requester can react before IDLE.
    localparam int unsigned GAP_CYC = (GAP == 0) ? 1 : GAP * 2 * DIV;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               hi_q, hi_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [FRAME_W-1:0] word_q, word_d;
    logic               last_q, last_d;
    logic               lock_q, lock_d;
    logic               owner_q, owner_d;

    logic               sclk_q, sclk_d;
    logic               sdio_q, sdio_d;
    logic               csb_q, csb_d;
    logic               busy_q, busy_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;

    logic               grant0_c, grant1_c;
    logic               div_end_c;
    logic               frame_end_c;
    logic [FRAME_W-1:0] shift_c;

    assign div_end_c = (div_q == DIV_W'(DIV - 1));

    // Arbitration: a locked burst keeps the bus; otherwise DAC first, ADC only after DAC init
    always_comb begin
        grant0_c = bus_if.req0 && (!lock_q || !owner_q);
        grant1_c = bus_if.req1 && !grant0_c && (lock_q ? owner_q : done0_q);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, frame timing counters and grant capture
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        hi_d        = hi_q;
        gap_d       = gap_q;
        word_d      = word_q;
        last_d      = last_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        frame_end_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant0_c || grant1_c) begin
                    state_d = ST_SETUP;
                    div_d   = '0;
                    bit_d   = '0;
                    hi_d    = 1'b0;
                    owner_d = grant1_c;
                    word_d  = grant1_c ? bus_if.word1 : bus_if.word0;
                    last_d  = grant1_c ? bus_if.last1 : bus_if.last0;
                end
            end
            ST_SETUP: begin
                if (div_end_c) begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                    hi_d    = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT: begin
                if (!div_end_c) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (hi_q) begin
                        // falling edge: advance to the next data bit
                        hi_d  = 1'b0;
                        bit_d = bit_q + BIT_W'(1);
                    end else if (bit_q == BIT_W'(FRAME_W)) begin
                        frame_end_c = 1'b1;
                        state_d     = ST_GAP;
                        gap_d       = '0;
                        lock_d      = ~last_q;
                    end else begin
                        hi_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from next state so every pin is a flop aligned with state_q
    always_comb begin
        sclk_d  = 1'b0;
        sdio_d  = 1'b0;
        csb_d   = 1'b1;
        shift_c = word_d << bit_d;
        busy_d  = (state_d != ST_IDLE);
        ack0_d  = frame_end_c && !owner_q;
        ack1_d  = frame_end_c && owner_q;
        done0_d = done0_q | (frame_end_c && last_q && !owner_q);
        done1_d = done1_q | (frame_end_c && last_q && owner_q);
        if ((state_d == ST_SETUP) || (state_d == ST_SHIFT)) begin
            csb_d  = 1'b0;
            sdio_d = shift_c[FRAME_W-1];
            sclk_d = (state_d == ST_SHIFT) && hi_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            bit_q   <= '0;
            hi_q    <= 1'b0;
            gap_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            lock_q  <= 1'b0;
            owner_q <= 1'b0;
            sclk_q  <= 1'b0;
            sdio_q  <= 1'b0;
            csb_q   <= 1'b1;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            hi_q    <= hi_d;
            gap_q   <= gap_d;
            word_q  <= word_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            sclk_q  <= sclk_d;
            sdio_q  <= sdio_d;
            csb_q   <= csb_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign bus_if.sclk  = sclk_q;
    assign bus_if.sdio  = sdio_q;
    assign bus_if.csb   = csb_q;
    assign bus_if.busy  = busy_q;
    assign bus_if.owner = owner_q;
    assign bus_if.ack0  = ack0_q;
    assign bus_if.ack1  = ack1_q;
    assign bus_if.done0 = done0_q;
    assign bus_if.done1 = done1_q;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Bench for spi_cfg_arbiter: frame decoder monitor plus transaction-order reference model.
module tb_spi_cfg_arbiter;

    localparam int unsigned LOW_CYC  = 66;   // DIV*(2*FRAME_W+1) with DIV=2
    localparam int          ACK_WAIT = 2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    spi_cfg_arbiter_if #(.FRAME_W(16)) bus_a ();
    spi_cfg_arbiter_if #(.FRAME_W(16)) bus_b ();

    spi_cfg_arbiter #(.FRAME_W(16), .DIV(2), .GAP(1)) dut_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_if(bus_a.slave)
    );

    spi_cfg_arbiter #(.FRAME_W(16), .DIV(2), .GAP(0)) dut_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_if(bus_b.slave)
    );

    typedef struct {
        logic        pcsb;
        logic        psclk;
        logic        psdio;
        int          low;
        int          edges;
        logic [15:0] cap;
        logic        own;
    } mon_t;

    mon_t        mon [2];
    logic [16:0] got_a[$], got_b[$];
    logic [16:0] exp_a[$], exp_b[$];
    logic [15:0] burst_w [2][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int bus, input int who, input logic r,
                           input logic [15:0] w, input logic l);
        if (bus == 0 && who == 0) begin bus_a.req0 = r; bus_a.word0 = w; bus_a.last0 = l; end
        if (bus == 0 && who == 1) begin bus_a.req1 = r; bus_a.word1 = w; bus_a.last1 = l; end
        if (bus == 1 && who == 0) begin bus_b.req0 = r; bus_b.word0 = w; bus_b.last0 = l; end
        if (bus == 1 && who == 1) begin bus_b.req1 = r; bus_b.word1 = w; bus_b.last1 = l; end
    endtask

    function automatic logic get_ack(input int bus, input int who);
        if (bus == 0) return (who == 0) ? bus_a.ack0 : bus_a.ack1;
        return (who == 0) ? bus_b.ack0 : bus_b.ack1;
    endfunction

    // Packed view of every output for reset checks: csb,sclk,sdio,ack0,ack1,done0,done1,busy,owner
    function automatic logic [8:0] outs(input int bus);
        if (bus == 0)
            return {bus_a.csb, bus_a.sclk, bus_a.sdio, bus_a.ack0, bus_a.ack1,
                    bus_a.done0, bus_a.done1, bus_a.busy, bus_a.owner};
        return {bus_b.csb, bus_b.sclk, bus_b.sdio, bus_b.ack0, bus_b.ack1,
                bus_b.done0, bus_b.done1, bus_b.busy, bus_b.owner};
    endfunction

    task automatic wait_ack(input int bus, input int who);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!get_ack(bus, who) && n < ACK_WAIT);
        chk("ack_wait_bounded", 32'(n < ACK_WAIT), 32'd1);
    endtask

    // One requester engine: present each word, hold until its ack, then move on
    task automatic run_burst(input int bus, input int who, input int n, input int dly);
        repeat (dly) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            set_req(bus, who, 1'b1, burst_w[who][i], 1'(i == n - 1));
            wait_ack(bus, who);
        end
        set_req(bus, who, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic expect_frames(input int bus, input string tag);
        logic [16:0] g, e;
        repeat (2) @(negedge clk);
        if (bus == 0) begin
            chk({tag, "_frame_count"}, 32'(got_a.size()), 32'(exp_a.size()));
            while (got_a.size() > 0 && exp_a.size() > 0) begin
                g = got_a.pop_front();
                e = exp_a.pop_front();
                chk({tag, "_owner_word"}, 32'(g), 32'(e));
            end
            got_a.delete();
            exp_a.delete();
        end else begin
            chk({tag, "_frame_count"}, 32'(got_b.size()), 32'(exp_b.size()));
            while (got_b.size() > 0 && exp_b.size() > 0) begin
                g = got_b.pop_front();
                e = exp_b.pop_front();
                chk({tag, "_owner_word"}, 32'(g), 32'(e));
            end
            got_b.delete();
            exp_b.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Decode one SPI pin sample: rebuild frames and check pin rules
    task automatic mon_step(input int id, input logic rstn, input logic csb, input logic sclk,
                            input logic sdio, input logic a0, input logic a1, input logic own);
        mon_t m;
        m = mon[id];
        if (!rstn) begin
            m.pcsb = 1'b1; m.psclk = 1'b0; m.psdio = 1'b0; m.low = 0; m.edges = 0;
            mon[id] = m;
            return;
        end
        if (!csb) begin
            if (m.pcsb) begin
                m.low = 1; m.edges = 0; m.cap = '0; m.own = own;
            end else begin
                m.low++;
                if (!(m.psclk && !sclk)) chk("sdio_only_on_fall", 32'(sdio), 32'(m.psdio));
                if (sclk && !m.psclk) begin
                    m.edges++;
                    m.cap = {m.cap[14:0], sdio};
                end
            end
            chk("no_ack_in_frame", 32'({a0, a1}), 32'd0);
        end else begin
            chk("idle_sclk_low", 32'(sclk), 32'd0);
            chk("idle_sdio_low", 32'(sdio), 32'd0);
            if (!m.pcsb) begin
                chk("csb_low_cycles", 32'(m.low), 32'(LOW_CYC));
                chk("sclk_rising_edges", 32'(m.edges), 32'd16);
                chk("ack_at_csb_rise", 32'({a0, a1}), m.own ? 32'd1 : 32'd2);
                if (id == 0) got_a.push_back({m.own, m.cap});
                else         got_b.push_back({m.own, m.cap});
            end else begin
                chk("no_stray_ack", 32'({a0, a1}), 32'd0);
            end
        end
        m.pcsb = csb; m.psclk = sclk; m.psdio = sdio;
        mon[id] = m;
    endtask

    always @(negedge clk) begin
        mon_step(0, rst_n, bus_a.csb, bus_a.sclk, bus_a.sdio, bus_a.ack0, bus_a.ack1, bus_a.owner);
        mon_step(1, rst_n, bus_b.csb, bus_b.sclk, bus_b.sdio, bus_b.ack0, bus_b.ack1, bus_b.owner);
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout assertions=%0d", n_assert);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w, w2;
        int n0, n1, k;

        set_req(0, 0, 1'b0, 16'h0, 1'b0);
        set_req(0, 1, 1'b0, 16'h0, 1'b0);
        set_req(1, 0, 1'b0, 16'h0, 1'b0);
        set_req(1, 1, 1'b0, 16'h0, 1'b0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_a", 32'(outs(0)), 32'h100);
        chk("reset_outputs_b", 32'(outs(1)), 32'h100);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single DAC word A5C3
        burst_w[0][0] = 16'hA5C3;
        run_burst(0, 0, 1, 1);
        exp_a.push_back({1'b0, 16'hA5C3});
        expect_frames(0, "t1");
        chk("t1_done0", 32'(bus_a.done0), 32'd1);
        chk("t1_done1", 32'(bus_a.done1), 32'd0);

        // Dropping req mid-frame still completes exactly one frame
        w = 16'($urandom);
        @(negedge clk);
        set_req(0, 0, 1'b1, w, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!bus_a.busy && k < 20);
        chk("t5_granted", 32'(bus_a.busy), 32'd1);
        repeat (30) @(negedge clk);
        set_req(0, 0, 1'b0, 16'h0, 1'b0);
        wait_ack(0, 0);
        repeat (100) @(negedge clk);
        exp_a.push_back({1'b0, w});
        expect_frames(0, "t5");

        // Reset 20 cycles into a frame, then a clean frame
        w  = 16'($urandom);
        w2 = 16'($urandom);
        @(negedge clk);
        set_req(0, 0, 1'b1, w, 1'b0);
        k = 0;
        do begin @(negedge clk); k++; end while (bus_a.csb && k < 20);
        chk("t4_frame_started", 32'(bus_a.csb), 32'd0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_reset_pins", 32'({bus_a.csb, bus_a.sclk, bus_a.sdio, bus_a.busy,
                                  bus_a.ack0, bus_a.done0}), 32'h20);
        set_req(0, 0, 1'b1, w2, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("t4_no_partial_frame", 32'(got_a.size()), 32'd0);
        wait_ack(0, 0);
        set_req(0, 0, 1'b0, 16'h0, 1'b0);
        exp_a.push_back({1'b0, w2});
        expect_frames(0, "t4");
        chk("t4_done0", 32'(bus_a.done0), 32'd1);

        // From reset: ADC waits for the whole DAC burst
        for (int it = 0; it < 2; it++) begin
            do_reset();
            n0 = int'($urandom_range(1, 3));
            n1 = int'($urandom_range(1, 3));
            for (int i = 0; i < 4; i++) begin
                burst_w[0][i] = 16'($urandom);
                burst_w[1][i] = 16'($urandom);
            end
            for (int i = 0; i < n0; i++) exp_a.push_back({1'b0, burst_w[0][i]});
            for (int i = 0; i < n1; i++) exp_a.push_back({1'b1, burst_w[1][i]});
            fork
                run_burst(0, 1, n1, 0);
                run_burst(0, 0, n0, 8);
            join
            expect_frames(0, "t2");
            chk("t2_done0", 32'(bus_a.done0), 32'd1);
            chk("t2_done1", 32'(bus_a.done1), 32'd1);
        end

        // Open ADC burst keeps the bus while the DAC is requesting
        n1 = int'($urandom_range(2, 3));
        n0 = int'($urandom_range(1, 2));
        for (int i = 0; i < 4; i++) begin
            burst_w[0][i] = 16'($urandom);
            burst_w[1][i] = 16'($urandom);
        end
        for (int i = 0; i < n1; i++) exp_a.push_back({1'b1, burst_w[1][i]});
        for (int i = 0; i < n0; i++) exp_a.push_back({1'b0, burst_w[0][i]});
        fork
            run_burst(0, 1, n1, 0);
            begin
                wait_ack(0, 1);
                chk("t3_done1_sticky", 32'(bus_a.done1), 32'd1);
                run_burst(0, 0, n0, 0);
            end
        join
        expect_frames(0, "t3");

        // GAP=0 instance: back-to-back DAC words
        for (int i = 0; i < 3; i++) begin
            burst_w[0][i] = 16'($urandom);
            exp_b.push_back({1'b0, burst_w[0][i]});
        end
        run_burst(1, 0, 3, 0);
        expect_frames(1, "t6");
        chk("t6_done0", 32'(bus_b.done0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
